// File: rtl/sccb_cfg_pkg.sv
// Shared types and constants for the OV7670 SCCB register-table sequencer.
package sccb_cfg_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, ISSUE, WAIT, DELAY, READY} state_t;

  localparam logic [15:0] END_MARKER   = 16'hFFFF;
  localparam logic [7:0]  DELAY_PREFIX = 8'hFF;

  function automatic logic is_delay(input logic [15:0] entry);
    return (entry[15:8] == DELAY_PREFIX) && (entry != END_MARKER);
  endfunction

endpackage

// File: rtl/sccb_delay_timer.sv
// Down-counter for table delay entries; done marks the last cycle of the delay.
module sccb_delay_timer
  import sccb_cfg_pkg::*;
#(
  parameter int TICKS_PER_UNIT = 1000,
  parameter int CW = $clog2(255 * TICKS_PER_UNIT + 1)
) (
  input  logic          sccb_clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] count;

  always_ff @(posedge sccb_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Raised on the final decrement so the delay lasts exactly load_val cycles.
  assign done = (count == CW'(1));

endmodule

// File: rtl/sccb_cfg_sequencer.sv
// Walks the SCCB register ROM issuing one write per entry (with retries and
// delays), then serves single runtime register writes.
module sccb_cfg_sequencer
  import sccb_cfg_pkg::*;
#(
  parameter int ROM_AW         = 8,
  parameter int MAX_RETRY      = 3,
  parameter int TICKS_PER_UNIT = 1000
) (
  input  logic              sccb_clk,
  input  logic              reset,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic              o_start,
  output logic [7:0]        o_reg_addr,
  output logic [7:0]        o_reg_data,
  input  logic              i_done,
  input  logic              i_ack_error,
  input  logic              i_req,
  input  logic [7:0]        i_req_addr,
  input  logic [7:0]        i_req_data,
  output logic              o_req_ack,
  output logic              o_req_err,
  output logic              o_init_done,
  output logic              o_init_err,
  output logic [7:0]        o_err_count
);

  localparam int CW = $clog2(255 * TICKS_PER_UNIT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_t            state, state_n;
  logic [RW-1:0]     retry, retry_n;
  logic              rt, rt_n;
  logic [ROM_AW-1:0] rom_addr_n;
  logic              start_n, req_ack_n, req_err_n, init_done_n, init_err_n;
  logic [7:0]        reg_addr_n, reg_data_n, err_count_n;
  logic              advance, fail, timer_load, timer_done;
  logic [CW-1:0]     delay_ticks;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign delay_ticks = CW'(i_rom_data[7:0]) * CW'(TICKS_PER_UNIT);

  sccb_delay_timer #(
    .TICKS_PER_UNIT(TICKS_PER_UNIT),
    .CW            (CW)
  ) u_timer (
    .sccb_clk(sccb_clk),
    .reset   (reset),
    .load    (timer_load),
    .load_val(delay_ticks),
    .done    (timer_done)
  );

  always_ff @(posedge sccb_clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      retry       <= '0;
      rt          <= 1'b0;
      o_rom_addr  <= '0;
      o_start     <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_data  <= '0;
      o_req_ack   <= 1'b0;
      o_req_err   <= 1'b0;
      o_init_done <= 1'b0;
      o_init_err  <= 1'b0;
      o_err_count <= '0;
    end else begin
      state       <= state_n;
      retry       <= retry_n;
      rt          <= rt_n;
      o_rom_addr  <= rom_addr_n;
      o_start     <= start_n;
      o_reg_addr  <= reg_addr_n;
      o_reg_data  <= reg_data_n;
      o_req_ack   <= req_ack_n;
      o_req_err   <= req_err_n;
      o_init_done <= init_done_n;
      o_init_err  <= init_err_n;
      o_err_count <= err_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    retry_n     = retry;
    rt_n        = rt;
    rom_addr_n  = o_rom_addr;
    start_n     = 1'b0;
    reg_addr_n  = o_reg_addr;
    reg_data_n  = o_reg_data;
    req_ack_n   = 1'b0;
    req_err_n   = 1'b0;
    init_done_n = o_init_done;
    init_err_n  = o_init_err;
    err_count_n = o_err_count;
    advance     = 1'b0;
    fail        = 1'b0;
    timer_load  = 1'b0;

    case (state)
      FETCH: state_n = DECODE;
      DECODE: begin
        if (i_rom_data == END_MARKER) begin
          init_done_n = 1'b1;
          state_n     = READY;
        end else if (is_delay(i_rom_data)) begin
          if (i_rom_data[7:0] == 8'd0) begin
            advance = 1'b1;
          end else begin
            timer_load = 1'b1;
            state_n    = DELAY;
          end
        end else begin
          reg_addr_n = i_rom_data[15:8];
          reg_data_n = i_rom_data[7:0];
          retry_n    = '0;
          rt_n       = 1'b0;
          state_n    = ISSUE;
        end
      end
      ISSUE: begin
        start_n = 1'b1;
        state_n = WAIT;
      end
      WAIT: begin
        if (i_done) begin
          if (i_ack_error && (retry != RW'(MAX_RETRY))) begin
            retry_n = retry + 1'b1;
            state_n = ISSUE;
          end else begin
            fail = i_ack_error;
            if (fail) err_count_n = sat_inc(o_err_count);
            if (rt) begin
              req_ack_n = 1'b1;
              req_err_n = fail;
              state_n   = READY;
            end else begin
              if (fail) init_err_n = 1'b1;
              advance = 1'b1;
            end
          end
        end
      end
      DELAY: if (timer_done) advance = 1'b1;
      READY: begin
        // The requester still holds i_req during its ack cycle; don't re-serve it.
        if (i_req && !o_req_ack) begin
          reg_addr_n = i_req_addr;
          reg_data_n = i_req_data;
          retry_n    = '0;
          rt_n       = 1'b1;
          state_n    = ISSUE;
        end
      end
      default: state_n = FETCH;
    endcase

    // A wrapped table address is treated like the end marker.
    if (advance) begin
      rom_addr_n = o_rom_addr + 1'b1;
      if (&o_rom_addr) begin
        init_done_n = 1'b1;
        state_n     = READY;
      end else begin
        state_n = FETCH;
      end
    end
  end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Self-checking bench: table-driven ROM walk plus runtime and reset sequences.
module tb_sccb_cfg_sequencer;

  localparam int TPU = 10;
  localparam int LAT = 3;

  logic        sccb_clk, reset;
  logic [7:0]  o_rom_addr;
  logic [15:0] i_rom_data;
  logic        o_start;
  logic [7:0]  o_reg_addr, o_reg_data;
  logic        i_done, i_ack_error;
  logic        i_req;
  logic [7:0]  i_req_addr, i_req_data;
  logic        o_req_ack, o_req_err, o_init_done, o_init_err;
  logic [7:0]  o_err_count;

  typedef struct {
    logic [15:0] entry;
    int          nacks;
    int          attempts;
    int          gap;
    int          err;
    int          ierr;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } start_t;

  start_t      sq[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] rom [256];
  int          nack_left [256];

  sccb_cfg_sequencer #(
    .ROM_AW        (8),
    .MAX_RETRY     (3),
    .TICKS_PER_UNIT(TPU)
  ) dut (
    .sccb_clk   (sccb_clk),
    .reset      (reset),
    .o_rom_addr (o_rom_addr),
    .i_rom_data (i_rom_data),
    .o_start    (o_start),
    .o_reg_addr (o_reg_addr),
    .o_reg_data (o_reg_data),
    .i_done     (i_done),
    .i_ack_error(i_ack_error),
    .i_req      (i_req),
    .i_req_addr (i_req_addr),
    .i_req_data (i_req_data),
    .o_req_ack  (o_req_ack),
    .o_req_err  (o_req_err),
    .o_init_done(o_init_done),
    .o_init_err (o_init_err),
    .o_err_count(o_err_count)
  );

  initial begin
    sccb_clk = 1'b0;
    forever #5 sccb_clk = ~sccb_clk;
  end

  always @(posedge sccb_clk) cyc <= cyc + 1;

  // Synchronous ROM: data follows the address by one clock.
  always @(posedge sccb_clk) i_rom_data <= rom[o_rom_addr];

  // SCCB slave: i_done LAT cycles after each o_start, nacking per target address.
  initial begin
    int     cd;
    start_t r;
    cd = 0;
    i_done = 1'b0;
    i_ack_error = 1'b0;
    forever begin
      @(negedge sccb_clk);
      i_done = 1'b0;
      i_ack_error = 1'b0;
      if (reset) begin
        cd = 0;
      end else if (o_start) begin
        r.addr = o_reg_addr;
        r.data = o_reg_data;
        r.cyc  = cyc;
        sq.push_back(r);
        cd = LAT;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          i_done = 1'b1;
          if (nack_left[o_reg_addr] > 0) begin
            i_ack_error = 1'b1;
            nack_left[o_reg_addr]--;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic get_start(output start_t r, output bit ok);
    int n;
    n = 0;
    while (sq.size() == 0 && n < 400) begin
      @(negedge sccb_clk);
      n++;
    end
    if (sq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL start_timeout actual=none required=o_start");
      r.addr = '0;
      r.data = '0;
      r.cyc  = 0;
      ok = 1'b0;
    end else begin
      r  = sq.pop_front();
      ok = 1'b1;
    end
  endtask

  task automatic wait_init(output int t);
    int n;
    n = 0;
    while (!o_init_done && n < 400) begin
      @(negedge sccb_clk);
      n++;
    end
    t = cyc;
    check("init_done", o_init_done, 1);
  endtask

  task automatic wait_ack(output int t);
    int n;
    n = 0;
    while (!o_req_ack && n < 200) begin
      @(negedge sccb_clk);
      n++;
    end
    t = cyc;
    check("req_ack_seen", o_req_ack, 1);
  endtask

  initial begin
    vec_t   vecs [9];
    vec_t   v;
    start_t r;
    bit     ok;
    int     n, t0, dwell, last_cyc, t_done, t_ack, ack_cnt;

    // entry, nacks, attempts, gap from previous o_start, err_count, init_err
    vecs[0] = '{16'h1280, 0,   1, 0,       0, 0};
    vecs[1] = '{16'h1101, 0,   1, LAT + 4, 0, 0};
    vecs[2] = '{16'h40D0, 2,   3, LAT + 4, 0, 0};
    vecs[3] = '{16'h55AA, 255, 4, LAT + 4, 0, 0};
    vecs[4] = '{16'hFF05, 0,   0, 0,       0, 0};
    vecs[5] = '{16'h3A04, 0,   1, 0,       1, 1};
    vecs[6] = '{16'hFF00, 0,   0, 0,       0, 0};
    vecs[7] = '{16'h6B4A, 0,   1, 0,       1, 1};
    vecs[8] = '{16'hFFFF, 0,   0, 0,       0, 0};

    reset = 1'b1;
    i_req = 1'b0;
    i_req_addr = '0;
    i_req_data = '0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 16'hFFFF;
      nack_left[i] = 0;
    end
    for (int i = 0; i < 9; i++) begin
      rom[i] = vecs[i].entry;
      if (vecs[i].entry[15:8] != 8'hFF) nack_left[vecs[i].entry[15:8]] = vecs[i].nacks;
    end

    repeat (3) @(negedge sccb_clk);
    check("rst_rom_addr", o_rom_addr, 0);
    check("rst_start", o_start, 0);
    check("rst_reg", {o_reg_addr, o_reg_data}, 0);
    check("rst_flags", {o_req_ack, o_req_err, o_init_done, o_init_err}, 0);
    check("rst_err_count", o_err_count, 0);

    reset = 1'b0;
    i_req = 1'b1;
    i_req_addr = 8'h13;
    i_req_data = 8'hE7;

    last_cyc = 0;
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      if (v.entry[15:8] == 8'hFF) begin
        if (v.entry != 16'hFFFF && v.entry[7:0] != 8'd0) begin
          n = 0;
          while (o_rom_addr != 8'(i) && n < 100) begin
            @(negedge sccb_clk);
            n++;
          end
          t0 = cyc;
          n = 0;
          while (o_rom_addr == 8'(i) && n < 300) begin
            @(negedge sccb_clk);
            n++;
          end
          dwell = cyc - t0;
          check_range("delay_dwell", dwell, int'(v.entry[7:0]) * TPU - 2, int'(v.entry[7:0]) * TPU + 4);
        end
      end else begin
        for (int a = 0; a < v.attempts; a++) begin
          get_start(r, ok);
          if (!ok) break;
          check($sformatf("tbl%0d_addr", i), r.addr, v.entry[15:8]);
          check($sformatf("tbl%0d_data", i), r.data, v.entry[7:0]);
          if (a == 0) begin
            check($sformatf("tbl%0d_err_count", i), o_err_count, v.err);
            check($sformatf("tbl%0d_init_err", i), o_init_err, v.ierr);
            if (v.gap > 0) check($sformatf("tbl%0d_gap", i), r.cyc - last_cyc, v.gap);
          end else begin
            check($sformatf("tbl%0d_retry_gap", i), r.cyc - last_cyc, LAT + 2);
          end
          last_cyc = r.cyc;
        end
      end
    end

    // Table end; the request held since reset is only served now.
    wait_init(t_done);
    check("end_init_err", o_init_err, 1);
    check("end_err_count", o_err_count, 1);
    check("end_rom_addr", o_rom_addr, 8);
    get_start(r, ok);
    check("req1_addr", r.addr, 8'h13);
    check("req1_data", r.data, 8'hE7);
    check("req1_latency", r.cyc - t_done, 2);
    wait_ack(t_ack);
    check("req1_err", o_req_err, 0);
    check("req1_ack_latency", t_ack - r.cyc, LAT + 1);
    @(negedge sccb_clk);
    i_req = 1'b0;
    check("req1_ack_pulse", o_req_ack, 0);
    ack_cnt = 0;
    repeat (20) begin
      @(negedge sccb_clk);
      if (o_req_ack) ack_cnt++;
    end
    check("req1_extra_acks", ack_cnt, 0);
    check("req1_extra_starts", sq.size(), 0);

    // Runtime write that never acks.
    nack_left[8'h2C] = 255;
    i_req_addr = 8'h2C;
    i_req_data = 8'h5A;
    i_req = 1'b1;
    for (int a = 0; a < 4; a++) begin
      get_start(r, ok);
      check("req2_addr", {r.addr, r.data}, 16'h2C5A);
    end
    wait_ack(t_ack);
    check("req2_err", o_req_err, 1);
    check("req2_err_count", o_err_count, 2);
    check("req2_init_err", o_init_err, 1);
    @(negedge sccb_clk);
    i_req = 1'b0;
    repeat (20) @(negedge sccb_clk);
    check("req2_attempts", sq.size(), 0);

    // Short table: first entry fails, reset lands while waiting on the 2nd.
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1280;
    rom[1] = 16'h1101;
    nack_left[8'h12] = 255;
    nack_left[8'h11] = 0;
    reset = 1'b1;
    repeat (2) @(negedge sccb_clk);
    sq.delete();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) get_start(r, ok);
    get_start(r, ok);
    check("rstB_second", {r.addr, r.data}, 16'h1101);
    check("rstB_pre_err", o_err_count, 1);
    @(negedge sccb_clk);
    reset = 1'b1;
    #1;
    check("midrst_rom_addr", o_rom_addr, 0);
    check("midrst_reg", {o_reg_addr, o_reg_data}, 0);
    check("midrst_flags", {o_start, o_req_ack, o_req_err, o_init_done, o_init_err}, 0);
    check("midrst_err_count", o_err_count, 0);
    nack_left[8'h12] = 0;
    repeat (2) @(negedge sccb_clk);
    sq.delete();
    reset = 1'b0;
    get_start(r, ok);
    check("rerun_first", {r.addr, r.data}, 16'h1280);
    last_cyc = r.cyc;
    get_start(r, ok);
    check("rerun_second", {r.addr, r.data}, 16'h1101);
    check("rerun_gap", r.cyc - last_cyc, LAT + 4);
    wait_init(t_done);
    check("rerun_err_count", o_err_count, 0);
    check("rerun_init_err", o_init_err, 0);
    repeat (10) @(negedge sccb_clk);
    check("rerun_starts", sq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sccb_cfg_sequencer.md
# sccb_cfg_sequencer

Walks the OV7670 register table in the SCCB ROM and issues one SCCB write per entry to the SCCB master. Handles end-of-table and delay entries and retries writes that fail on ack. After the table completes it serves single runtime register-write requests from the rest of the design, such as exposure or gain tweaks. It sits between the SCCB ROM and the SCCB master inside the camera setup path, and it replaces ad-hoc start/address sequencing.

## Interface
- ROM_AW, 8, ROM address width.
- MAX_RETRY, 3, re-issues allowed after the first failed attempt of one write.
- TICKS_PER_UNIT, 1000, sccb_clk cycles per delay unit.
- sccb_clk  in  1  clock; every output is registered on it.
- reset  in  1  reset, asynchronous, active-high; clock sccb_clk.
- o_rom_addr  out  ROM_AW  table address.
- i_rom_data  in  16  {reg_addr, reg_data}; valid one cycle after o_rom_addr changes.
- o_start  out  1  one-cycle pulse to the SCCB master.
- o_reg_addr / o_reg_data  out  8 / 8  write target and value; held from o_start until i_done.
- i_done  in  1  one-cycle pulse from the SCCB master marking the end of a write.
- i_ack_error  in  1  sampled only in the cycle i_done is high.
- i_req  in  1  runtime write request; held high until o_req_ack.
- i_req_addr / i_req_data  in  8 / 8  runtime write target and value; stable while i_req is high.
- o_req_ack  out  1  one-cycle pulse when the runtime write finishes.
- o_req_err  out  1  valid with o_req_ack; 1 when all retries failed.
- o_init_done  out  1  level; the table is finished.
- o_init_err  out  1  sticky; at least one table entry exhausted its retries.
- o_err_count  out  8  count of failed writes (table and runtime); saturates at 255.

## Operation
- Reset values: every output is 0. State is FETCH and the retry counter is 0.
- States: FETCH, DECODE, ISSUE, WAIT, DELAY, READY.
- FETCH: drive o_rom_addr and go to DECODE the next cycle.
- DECODE: sample i_rom_data.
  - 16'hFFFF is the end marker: set o_init_done and go to READY.
  - 16'hFFxx with xx != FF is a delay entry: load the delay timer with xx*TICKS_PER_UNIT and go to DELAY. If xx = 0, advance the address and go straight to FETCH.
  - Any other value: latch o_reg_addr and o_reg_data, clear the retry counter, go to ISSUE.
- ISSUE: assert o_start for exactly one cycle, then go to WAIT.
- WAIT: hold until i_done.
  - i_done with no error: the write succeeded.
  - i_done with i_ack_error and retries < MAX_RETRY: increment the retry counter and return to ISSUE.
  - i_done with i_ack_error and retries = MAX_RETRY: the write failed. Increment o_err_count; if this is a table write, set o_init_err.
- After a table write finishes (success or failure), or a delay expires: increment o_rom_addr.
  - If o_rom_addr was all-ones, the table has wrapped: treat it as the end marker (set o_init_done, go to READY).
  - Otherwise go to FETCH.
- DELAY: decrement the timer each cycle. Leave when it reaches 0.
- READY: if i_req is high, latch i_req_addr/i_req_data and go to ISSUE, with completion routed to the runtime path. When the runtime write finishes: pulse o_req_ack (with o_req_err if it failed), then return to READY. i_req must drop in the cycle after o_req_ack.
- i_req is ignored until o_init_done is set. Table writes always take priority over runtime requests; a request seen during init waits and is not lost.
- i_done or i_ack_error outside WAIT is ignored.
- Reset mid-transaction: abort immediately, return to address 0, and re-run the whole table.

## Timing
- From entering FETCH to o_start is 3 cycles (FETCH, DECODE, ISSUE).
- From i_done to the next table o_start is 4 cycles (advance, FETCH, DECODE, ISSUE). A retry o_start follows i_done by 2 cycles.
- From i_req high in READY to o_start is 2 cycles.
- o_req_ack comes 1 cycle after the final i_done.
- A delay entry xx holds for xx*TICKS_PER_UNIT cycles ±2 of overhead before the next FETCH.
- o_init_done rises 1 cycle after the DECODE of the end marker.

## Structure
- Package sccb_cfg_pkg holds:
  - the state enum;
  - END_MARKER = 16'hFFFF;
  - DELAY_PREFIX = 8'hFF;
  - a function is_delay(entry).
- Sub-module sccb_delay_timer: load value, load strobe, done flag. Its counter width is sized from 255*TICKS_PER_UNIT.

## Test plan
- Table {12 80, 11 01, FFFF}, slave always acks. Required: 2 o_start pulses with addr/data 12/80 then 11/01; o_init_done=1; o_err_count=0.
- Entry 40 D0 with ack error on the first 2 attempts. Required: 3 o_start pulses with identical addr/data; the 3rd succeeds; o_init_err=0.
- Entry with ack error on every attempt, MAX_RETRY=3. Required: 4 attempts; o_init_err=1; o_err_count=1; the sequencer moves on to the next entry.
- Delay entry FF05 with TICKS_PER_UNIT=10. Required: a gap of 50±2 cycles with no o_start before the next entry.
- i_req=1 (addr 13, data E7) held during init. Required: served only after o_init_done; o_req_ack pulses once; o_req_err=0.
- Reset asserted while in WAIT on the 2nd entry. Required: all outputs return to 0 and the table restarts at o_rom_addr=0.
